mem_wb_stage: RTL and testbench

// - MEM stage plus MEM/WB pipeline register; consumes EXE/MEM register outputs, produces write-back operands.
// - Holds 2**ADDR_W x 8 data memory with a configurable multi-cycle access latency.
// - Asserts stall upstream while an access is in flight; non-memory ops pass straight through.

---
 rtl/mem_wb_stage_pkg.sv | 16 +
 rtl/mem_wb_stage_if.sv | 26 ++
 rtl/mem_wb_stage_data_mem.sv | 24 ++
 rtl/mem_wb_stage.sv | 114 +++++++++++
 tb/tb_mem_wb_stage.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, FSM state encoding and bubble constants for the MEM/WB stage.
package mem_wb_stage_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic              BUBBLE_REGWR = 1'b0;
    localparam logic [DATA_W-1:0] BUBBLE_DATA  = '0;
    localparam logic [REG_W-1:0]  BUBBLE_RD    = '0;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EXE/MEM operand inputs, stall back-pressure and MEM/WB write-back outputs.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    logic              regWr_IN;
    logic              memWr_IN;
    logic              memRd_IN;
    logic [DATA_W-1:0] aluRes_IN;
    logic [DATA_W-1:0] memWrData_IN;
    logic [REG_W-1:0]  rd_IN;
    logic              stall_OUT;
    logic              regWr_OUT;
    logic [DATA_W-1:0] wbData_OUT;
    logic [REG_W-1:0]  rd_OUT;

    modport master (
        output regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
        input  stall_OUT, regWr_OUT, wbData_OUT, rd_OUT
    );

    modport slave (
        input  regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
        output stall_OUT, regWr_OUT, wbData_OUT, rd_OUT
    );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Data memory: synchronous write, combinational read; contents survive reset.
module data_mem
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W] = '{default: '0};

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with multi-cycle data memory access and the MEM/WB pipeline register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);

    localparam int unsigned    CNT_W    = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_access;
    logic               w_load;
    logic               w_stall;
    logic               w_complete;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_rdata;

    logic               r_regWr;
    logic [DATA_W-1:0]  r_wbData;
    logic [REG_W-1:0]   r_rd;

    assign w_access = bus.memRd_IN | bus.memWr_IN;
    // A combined read+write request behaves as a plain store.
    assign w_load   = bus.memRd_IN & ~bus.memWr_IN;
    assign w_addr   = bus.aluRes_IN[ADDR_W-1:0];
    assign w_we     = w_complete & bus.memWr_IN & ~rst;

    data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (bus.memWrData_IN),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (MEM_LATENCY == 1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (r_cnt < CNT_LAST) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Stalled cycles push a bubble; otherwise the instruction retires into MEM/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regWr  <= 1'b0;
            r_wbData <= '0;
            r_rd     <= '0;
        end else if (w_stall) begin
            r_regWr  <= BUBBLE_REGWR;
            r_wbData <= BUBBLE_DATA;
            r_rd     <= BUBBLE_RD;
        end else begin
            r_regWr  <= bus.regWr_IN;
            r_wbData <= w_load ? w_rdata : bus.aluRes_IN;
            r_rd     <= bus.rd_IN;
        end
    end

    assign bus.stall_OUT  = w_stall;
    assign bus.regWr_OUT  = r_regWr;
    assign bus.wbData_OUT = r_wbData;
    assign bus.rd_OUT     = r_rd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage at latencies 1..4, one stage instance per latency.
module tb_mem_wb_stage;

    logic clk = 1'b0;
    logic rst1, rst2, rst3, rst4;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if if1 ();
    mem_wb_stage_if if2 ();
    mem_wb_stage_if if3 ();
    mem_wb_stage_if if4 ();

    mem_wb_stage #(.MEM_LATENCY(1), .ADDR_W(8)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    mem_wb_stage #(.MEM_LATENCY(2), .ADDR_W(8)) dut2 (.clk(clk), .rst(rst2), .bus(if2));
    mem_wb_stage #(.MEM_LATENCY(3), .ADDR_W(8)) dut3 (.clk(clk), .rst(rst3), .bus(if3));
    mem_wb_stage #(.MEM_LATENCY(4), .ADDR_W(8)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if1.regWr_IN = 0; if1.memWr_IN = 0; if1.memRd_IN = 0; if1.aluRes_IN = 0; if1.memWrData_IN = 0; if1.rd_IN = 0;
        if2.regWr_IN = 0; if2.memWr_IN = 0; if2.memRd_IN = 0; if2.aluRes_IN = 0; if2.memWrData_IN = 0; if2.rd_IN = 0;
        if3.regWr_IN = 0; if3.memWr_IN = 0; if3.memRd_IN = 0; if3.aluRes_IN = 0; if3.memWrData_IN = 0; if3.rd_IN = 0;
        if4.regWr_IN = 0; if4.memWr_IN = 0; if4.memRd_IN = 0; if4.aluRes_IN = 0; if4.memWrData_IN = 0; if4.rd_IN = 0;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        idle_all();
        rst1 = 1; rst2 = 1; rst3 = 1; rst4 = 1;
        step(); step();
        rst1 = 0; rst2 = 0; rst3 = 0; rst4 = 0;
        #1;
        // {stall, regWr, wbData, rd} packed per instance, all must be zero
        got = {if1.stall_OUT, if1.regWr_OUT, if1.wbData_OUT, if1.rd_OUT};
        n_vec++; if (got !== 13'h0) begin n_err++; $display("FAIL reset_L1 got=%h exp=0", got); end
        got = {if2.stall_OUT, if2.regWr_OUT, if2.wbData_OUT, if2.rd_OUT};
        n_vec++; if (got !== 13'h0) begin n_err++; $display("FAIL reset_L2 got=%h exp=0", got); end
        got = {if3.stall_OUT, if3.regWr_OUT, if3.wbData_OUT, if3.rd_OUT};
        n_vec++; if (got !== 13'h0) begin n_err++; $display("FAIL reset_L3 got=%h exp=0", got); end
        got = {if4.stall_OUT, if4.regWr_OUT, if4.wbData_OUT, if4.rd_OUT};
        n_vec++; if (got !== 13'h0) begin n_err++; $display("FAIL reset_L4 got=%h exp=0", got); end
    endtask

    task automatic test_alu_passthrough();
        if2.regWr_IN = 1; if2.aluRes_IN = 8'h5A; if2.rd_IN = 3'd3;
        #1;
        n_vec++; if (if2.stall_OUT !== 1'b0) begin n_err++; $display("FAIL alu_stall got=%b exp=0", if2.stall_OUT); end
        step();
        n_vec++; if (if2.regWr_OUT !== 1'b1) begin n_err++; $display("FAIL alu_regWr got=%b exp=1", if2.regWr_OUT); end
        n_vec++; if (if2.wbData_OUT !== 8'h5A) begin n_err++; $display("FAIL alu_wbData got=%h exp=5a", if2.wbData_OUT); end
        n_vec++; if (if2.rd_OUT !== 3'd3) begin n_err++; $display("FAIL alu_rd got=%0d exp=3", if2.rd_OUT); end
        idle_all();
    endtask

    task automatic test_store_load_l3();
        if3.memWr_IN = 1; if3.aluRes_IN = 8'h10; if3.memWrData_IN = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (if3.stall_OUT !== (i < 2)) begin n_err++; $display("FAIL st3_stall cyc=%0d got=%b exp=%b", i, if3.stall_OUT, i < 2); end
            step();
            if (i < 2) begin
                n_vec++; if (if3.regWr_OUT !== 1'b0) begin n_err++; $display("FAIL st3_bubble cyc=%0d got=%b exp=0", i, if3.regWr_OUT); end
            end
        end
        n_vec++; if (if3.wbData_OUT !== 8'h10) begin n_err++; $display("FAIL st3_wbData got=%h exp=10", if3.wbData_OUT); end
        if3.memWr_IN = 0; if3.memRd_IN = 1; if3.regWr_IN = 1; if3.rd_IN = 3'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (if3.stall_OUT !== (i < 2)) begin n_err++; $display("FAIL ld3_stall cyc=%0d got=%b exp=%b", i, if3.stall_OUT, i < 2); end
            step();
            if (i < 2) begin
                n_vec++; if (if3.regWr_OUT !== 1'b0) begin n_err++; $display("FAIL ld3_bubble cyc=%0d got=%b exp=0", i, if3.regWr_OUT); end
            end
        end
        n_vec++; if (if3.wbData_OUT !== 8'hC3) begin n_err++; $display("FAIL ld3_wbData got=%h exp=c3", if3.wbData_OUT); end
        n_vec++; if (if3.rd_OUT !== 3'd5) begin n_err++; $display("FAIL ld3_rd got=%0d exp=5", if3.rd_OUT); end
        n_vec++; if (if3.regWr_OUT !== 1'b1) begin n_err++; $display("FAIL ld3_regWr got=%b exp=1", if3.regWr_OUT); end
        idle_all();
    endtask

    task automatic test_l1_back_to_back();
        if1.memWr_IN = 1; if1.aluRes_IN = 8'h00; if1.memWrData_IN = 8'h11;
        #1;
        n_vec++; if (if1.stall_OUT !== 1'b0) begin n_err++; $display("FAIL l1_st_stall got=%b exp=0", if1.stall_OUT); end
        step();
        n_vec++; if (if1.regWr_OUT !== 1'b0) begin n_err++; $display("FAIL l1_st_regWr got=%b exp=0", if1.regWr_OUT); end
        if1.memWr_IN = 0; if1.memRd_IN = 1; if1.regWr_IN = 1; if1.rd_IN = 3'd2;
        #1;
        n_vec++; if (if1.stall_OUT !== 1'b0) begin n_err++; $display("FAIL l1_ld_stall got=%b exp=0", if1.stall_OUT); end
        step();
        n_vec++; if (if1.wbData_OUT !== 8'h11) begin n_err++; $display("FAIL l1_ld_wbData got=%h exp=11", if1.wbData_OUT); end
        n_vec++; if (if1.rd_OUT !== 3'd2) begin n_err++; $display("FAIL l1_ld_rd got=%0d exp=2", if1.rd_OUT); end
        idle_all();
    endtask

    task automatic test_reset_mid_store();
        logic [11:0] got;
        if4.memWr_IN = 1; if4.aluRes_IN = 8'h20; if4.memWrData_IN = 8'hFF;
        #1;
        n_vec++; if (if4.stall_OUT !== 1'b1) begin n_err++; $display("FAIL rms_stall1 got=%b exp=1", if4.stall_OUT); end
        step();
        n_vec++; if (if4.stall_OUT !== 1'b1) begin n_err++; $display("FAIL rms_stall2 got=%b exp=1", if4.stall_OUT); end
        rst4 = 1;
        step();
        rst4 = 0;
        idle_all();
        #1;
        got = {if4.regWr_OUT, if4.wbData_OUT, if4.rd_OUT};
        n_vec++; if (got !== 12'h0) begin n_err++; $display("FAIL rms_outs got=%h exp=0", got); end
        n_vec++; if (if4.stall_OUT !== 1'b0) begin n_err++; $display("FAIL rms_idle got=%b exp=0", if4.stall_OUT); end
        if4.memRd_IN = 1; if4.aluRes_IN = 8'h20; if4.regWr_IN = 1; if4.rd_IN = 3'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (if4.stall_OUT !== (i < 3)) begin n_err++; $display("FAIL rms_ld_stall cyc=%0d got=%b exp=%b", i, if4.stall_OUT, i < 3); end
            step();
        end
        n_vec++; if (if4.wbData_OUT !== 8'h00) begin n_err++; $display("FAIL rms_ld_wbData got=%h exp=00", if4.wbData_OUT); end
        n_vec++; if (if4.rd_OUT !== 3'd4) begin n_err++; $display("FAIL rms_ld_rd got=%0d exp=4", if4.rd_OUT); end
        idle_all();
    endtask

    task automatic test_both_set();
        if2.memRd_IN = 1; if2.memWr_IN = 1; if2.aluRes_IN = 8'h30; if2.memWrData_IN = 8'h77;
        if2.regWr_IN = 1; if2.rd_IN = 3'd6;
        #1;
        n_vec++; if (if2.stall_OUT !== 1'b1) begin n_err++; $display("FAIL both_stall got=%b exp=1", if2.stall_OUT); end
        step();
        n_vec++; if (if2.stall_OUT !== 1'b0) begin n_err++; $display("FAIL both_done got=%b exp=0", if2.stall_OUT); end
        step();
        n_vec++; if (if2.wbData_OUT !== 8'h30) begin n_err++; $display("FAIL both_wbData got=%h exp=30", if2.wbData_OUT); end
        n_vec++; if (if2.rd_OUT !== 3'd6) begin n_err++; $display("FAIL both_rd got=%0d exp=6", if2.rd_OUT); end
        // Read back the location to confirm the store half committed.
        if2.memWr_IN = 0; if2.rd_IN = 3'd7;
        step(); step();
        n_vec++; if (if2.wbData_OUT !== 8'h77) begin n_err++; $display("FAIL both_mem got=%h exp=77", if2.wbData_OUT); end
        idle_all();
    endtask

    task automatic test_back_to_back();
        if2.memWr_IN = 1; if2.aluRes_IN = 8'hFF; if2.memWrData_IN = 8'hAB;
        step(); step();
        if2.memWr_IN = 0; if2.memRd_IN = 1; if2.regWr_IN = 1; if2.rd_IN = 3'd1;
        #1;
        n_vec++; if (if2.stall_OUT !== 1'b1) begin n_err++; $display("FAIL b2b_restall got=%b exp=1", if2.stall_OUT); end
        step();
        n_vec++; if (if2.regWr_OUT !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got=%b exp=0", if2.regWr_OUT); end
        step();
        n_vec++; if (if2.wbData_OUT !== 8'hAB) begin n_err++; $display("FAIL b2b_wbData got=%h exp=ab", if2.wbData_OUT); end
        n_vec++; if (if2.regWr_OUT !== 1'b1) begin n_err++; $display("FAIL b2b_regWr got=%b exp=1", if2.regWr_OUT); end
        idle_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        idle_all();
        rst1 = 0; rst2 = 0; rst3 = 0; rst4 = 0;
        #1;
        test_reset();
        test_alu_passthrough();
        test_store_load_l3();
        test_l1_back_to_back();
        test_reset_mid_store();
        test_both_set();
        test_back_to_back();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
